// File: rtl/button_event_arbiter.sv
// button_event_arbiter: classifies button presses as SHORT/LONG and round-robin serializes them onto a valid/ready stream.
// Defining BUTTON_AUTOREPEAT_EN adds periodic REPEAT events while a long press is held.
module button_event_arbiter #(
    parameter int NUM_BUTTONS       = 4,
    parameter int LONG_PRESS_CYCLES = 1000,
    parameter int REPEAT_CYCLES     = 250
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_BUTTONS-1:0]         i_rising,
    input  logic [NUM_BUTTONS-1:0]         i_falling,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [$clog2(NUM_BUTTONS)-1:0] o_btn_idx,
    output logic [1:0]                     o_event_type,
    output logic [NUM_BUTTONS-1:0]         o_overflow,
    input  logic                           i_clear_overflow
);
    localparam int IW = $clog2(NUM_BUTTONS);
    localparam int CW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

    state_t                 state_q [NUM_BUTTONS];
    state_t                 state_d [NUM_BUTTONS];
    logic [CW-1:0]          cnt_q [NUM_BUTTONS];
    logic [CW-1:0]          cnt_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] short_q, short_d, long_q, long_d, rep_q;
    logic [NUM_BUTTONS-1:0] set_s, set_l, set_r, gnt_s, gnt_l, gnt_r;
    logic [NUM_BUTTONS-1:0] ovf_q, ovf_d, req;
    logic                   valid_q, valid_d, load, found;
    logic [IW-1:0]          idx_q, idx_d, ptr_q, ptr_d, win;
    logic [1:0]             type_q, type_d;

    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            set_s[i]   = 1'b0;
            set_l[i]   = 1'b0;
            case (state_q[i])
                IDLE: if (i_rising[i] && !i_falling[i]) begin
                    state_d[i] = PRESSED;
                    cnt_d[i]   = '0;
                end
                PRESSED: if (i_falling[i]) begin
                    state_d[i] = IDLE;
                    set_s[i]   = 1'b1;
                end else if (cnt_q[i] == CNT_LAST) begin
                    state_d[i] = LONG_HELD;
                    set_l[i]   = 1'b1;
                end else begin
                    cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
                end
                default: if (i_falling[i]) state_d[i] = IDLE;
            endcase
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [RW-1:0]          rcnt_q [NUM_BUTTONS];
    logic [RW-1:0]          rcnt_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] rep_d;

    // Repeat counter idles at 0 outside LONG_HELD, so each long hold starts a fresh period.
    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            rcnt_d[i] = '0;
            set_r[i]  = 1'b0;
            if (state_q[i] == LONG_HELD && !i_falling[i]) begin
                set_r[i]  = rcnt_q[i] == RW'(REPEAT_CYCLES - 1);
                rcnt_d[i] = set_r[i] ? '0 : rcnt_q[i] + 1'b1;
            end
        end
        rep_d = (rep_q & ~gnt_r) | set_r;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_BUTTONS; i++) rcnt_q[i] <= '0;
            rep_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            rep_q  <= rep_d;
        end
    end
`else
    assign set_r = '0;
    assign rep_q = '0;
`endif

    // Rotated search: first requester at or above the pointer, else the lowest requester.
    always_comb begin
        req   = short_q | long_q | rep_q;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (!found && req[i] && IW'(i) >= ptr_q) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
    end

    always_comb begin
        load    = !valid_q || i_ready;
        valid_d = load ? found : valid_q;
        idx_d   = (load && found) ? win : idx_q;
        type_d  = (load && found) ? (short_q[win] ? 2'b00 : long_q[win] ? 2'b01 : 2'b10) : type_q;
        ptr_d   = (load && found) ? ((win == IW'(NUM_BUTTONS - 1)) ? '0 : win + 1'b1) : ptr_q;
        gnt_s   = '0;
        gnt_l   = '0;
        gnt_r   = '0;
        if (load && found) begin
            gnt_s[win] = short_q[win];
            gnt_l[win] = !short_q[win] && long_q[win];
            gnt_r[win] = !short_q[win] && !long_q[win];
        end
        short_d = (short_q & ~gnt_s) | set_s;
        long_d  = (long_q & ~gnt_l) | set_l;
        ovf_d   = (i_clear_overflow ? '0 : ovf_q) | (set_s & short_q & ~gnt_s)
                | (set_l & long_q & ~gnt_l) | (set_r & rep_q & ~gnt_r);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            short_q <= '0;
            long_q  <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            type_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            type_q  <= type_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_btn_idx    = idx_q;
    assign o_event_type = type_q;
    assign o_overflow   = ovf_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: vector table, directed corner sequences and a timestamp-based reference model.
module tb_button_event_arbiter;
    localparam int N = 4;
    localparam int L = 1000;
    localparam int R = 250;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0, rdy = 1'b0, clr = 1'b0;
    logic [N-1:0] rise = '0, fall = '0;
    logic         o_valid;
    logic [1:0]   o_btn_idx, o_event_type;
    logic [N-1:0] o_overflow;
    int           total = 0, bad = 0;

    button_event_arbiter #(.NUM_BUTTONS(N), .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R)) dut (
        .i_clk(clk), .i_reset(rst), .i_rising(rise), .i_falling(fall),
        .o_valid(o_valid), .i_ready(rdy), .o_btn_idx(o_btn_idx), .o_event_type(o_event_type),
        .o_overflow(o_overflow), .i_clear_overflow(clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rs; logic [N-1:0] r, f; logic rd, c;
        logic v; logic [1:0] ix, ty; logic [N-1:0] ov;
    } vec_t;
    vec_t tbl [26];

    // Reference model: presses are timestamps; classification by elapsed edges.
    int           m_press [N];
    int           m_long [N];
    bit           m_pend [N][3];
    bit [N-1:0]   m_ovf;
    bit           m_v;
    int           m_idx, m_type, m_ptr, now;

    function automatic vec_t mk(logic rs, logic [N-1:0] r, logic [N-1:0] f, logic rd, logic c,
                                logic v, logic [1:0] ix, logic [1:0] ty, logic [N-1:0] ov);
        vec_t x;
        x.rs = rs; x.r = r; x.f = f; x.rd = rd; x.c = c; x.v = v; x.ix = ix; x.ty = ty; x.ov = ov;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; rise = '0; fall = '0; clr = 1'b0;
        tick;
        rst = 1'b0;
    endtask

    task automatic model_reset;
        for (int b = 0; b < N; b++) begin
            m_press[b] = -1;
            m_long[b]  = -1;
            for (int t = 0; t < 3; t++) m_pend[b][t] = 1'b0;
        end
        m_ovf = '0; m_v = 1'b0; m_idx = 0; m_type = 0; m_ptr = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] f, input logic rd,
                              input logic c, input logic rs);
        bit set [N][3];
        bit g [N][3];
        bit [N-1:0] nov;
        int w;
        now++;
        if (rs) begin
            model_reset;
            return;
        end
        nov = '0;
        w = -1;
        for (int b = 0; b < N; b++)
            for (int t = 0; t < 3; t++) begin
                set[b][t] = 1'b0;
                g[b][t]   = 1'b0;
            end
        if (!m_v || rd) begin
            for (int k = 0; k < N; k++) begin
                int b;
                b = (m_ptr + k) % N;
                if (w < 0 && (m_pend[b][0] || m_pend[b][1] || m_pend[b][2])) w = b;
            end
            m_v = (w >= 0);
            if (w >= 0) begin
                m_idx  = w;
                m_type = m_pend[w][0] ? 0 : m_pend[w][1] ? 1 : 2;
                g[w][m_type] = 1'b1;
                m_ptr = (w + 1) % N;
            end
        end
        for (int b = 0; b < N; b++) begin
            if (m_press[b] >= 0) begin
                if (f[b]) begin
                    if (m_long[b] < 0) set[b][0] = 1'b1;
                    m_press[b] = -1;
                    m_long[b]  = -1;
                end else if (m_long[b] < 0) begin
                    if (now - m_press[b] == L) begin
                        set[b][1] = 1'b1;
                        m_long[b] = now;
                    end
                end else if (REP && (now - m_long[b]) % R == 0) begin
                    set[b][2] = 1'b1;
                end
            end else if (r[b] && !f[b]) begin
                m_press[b] = now;
            end
            for (int t = 0; t < 3; t++) begin
                if (set[b][t] && m_pend[b][t] && !g[b][t]) nov[b] = 1'b1;
                m_pend[b][t] = (m_pend[b][t] && !g[b][t]) || set[b][t];
            end
        end
        m_ovf = (c ? '0 : m_ovf) | nov;
    endtask

    initial begin
        int n_s, n_l, n_r, rep_sum, cnt, unstable;
        bit stall;
        logic [8:0] act_w, exp_w;

        tbl[0]  = mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 4'b1011, 4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 4'b0000, 4'b1011, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 4'b0000, 4'b0000, 1, 0, 1, 0, 0, 0);
        tbl[4]  = mk(0, 4'b0000, 4'b0000, 1, 0, 1, 1, 0, 0);
        tbl[5]  = mk(0, 4'b0000, 4'b0000, 1, 0, 1, 3, 0, 0);
        tbl[6]  = mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 4'b1011, 4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 4'b0000, 4'b1011, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 4'b0000, 4'b0000, 1, 0, 1, 0, 0, 0);
        tbl[10] = mk(0, 4'b0000, 4'b0000, 1, 0, 1, 1, 0, 0);
        tbl[11] = mk(0, 4'b0000, 4'b0000, 1, 0, 1, 3, 0, 0);
        tbl[12] = mk(0, 4'b0010, 4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 4'b0000, 4'b0010, 1, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 4'b0000, 4'b0000, 1, 0, 1, 1, 0, 0);
        tbl[15] = mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 4'b1011, 4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 4'b0000, 4'b1011, 1, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 4'b0000, 4'b0000, 1, 0, 1, 3, 0, 0);
        tbl[19] = mk(0, 4'b0000, 4'b0000, 1, 0, 1, 0, 0, 0);
        tbl[20] = mk(0, 4'b0000, 4'b0000, 1, 0, 1, 1, 0, 0);
        tbl[21] = mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, 4'b0001, 4'b0001, 1, 0, 0, 0, 0, 0);
        tbl[23] = mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);
        tbl[24] = mk(0, 4'b0000, 4'b0001, 1, 0, 0, 0, 0, 0);
        tbl[25] = mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 26; i++) begin
            rst = tbl[i].rs; rise = tbl[i].r; fall = tbl[i].f; rdy = tbl[i].rd; clr = tbl[i].c;
            tick;
            chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].v);
            if (tbl[i].v) chk($sformatf("tbl%0d_idx_type", i), {o_btn_idx, o_event_type}, {tbl[i].ix, tbl[i].ty});
            chk($sformatf("tbl%0d_ovf", i), o_overflow, tbl[i].ov);
        end

        // Short press: rise at edge 0, fall at edge 10.
        do_reset; rdy = 1'b1;
        rise = 4'b0010; tick; rise = '0;
        repeat (9) tick;
        fall = 4'b0010; tick; fall = '0;
        chk("short_not_yet", o_valid, 1'b0);
        tick;
        chk("short_evt", {o_valid, o_btn_idx, o_event_type}, {1'b1, 2'd1, 2'b00});
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick;
            if (o_valid) cnt++;
        end
        chk("short_once", cnt, 0);

        // Long press on button 2, released at edge 1600.
        do_reset; rdy = 1'b1;
        rise = 4'b0100; tick; rise = '0;
        n_s = 0; n_l = 0; n_r = 0; rep_sum = 0;
        for (int e = 1; e <= 1700; e++) begin
            fall = (e == 1600) ? 4'b0100 : 4'b0000;
            tick;
            if (e == 1000) chk("long_not_yet", o_valid, 1'b0);
            if (e == 1001) chk("long_evt", {o_valid, o_btn_idx, o_event_type}, {1'b1, 2'd2, 2'b01});
            if (o_valid) begin
                if (o_event_type == 2'b00) n_s++;
                else if (o_event_type == 2'b01) n_l++;
                else begin
                    n_r++;
                    rep_sum += e;
                end
            end
        end
        fall = '0;
        chk("long_count", n_l, 1);
        chk("long_no_short", n_s, 0);
        chk("repeat_count", n_r, REP ? 2 : 0);
        chk("repeat_time", rep_sum, REP ? 1251 + 1501 : 0);

        // Backpressure with overflow, clear/new-overflow coincidence, then drain.
        do_reset; rdy = 1'b0;
        rise = 4'b0010; tick; rise = '0;
        fall = 4'b0010; tick; fall = '0;
        tick;
        chk("bp_first", {o_valid, o_btn_idx, o_event_type}, {1'b1, 2'd1, 2'b00});
        unstable = 0;
        for (int c = 0; c < 50; c++) begin
            rise = (c == 10 || c == 20) ? 4'b0001 : (c == 30 || c == 40) ? 4'b1000 : 4'b0000;
            fall = (c == 11 || c == 21) ? 4'b0001 : (c == 31 || c == 41) ? 4'b1000 : 4'b0000;
            clr  = (c == 41);
            tick;
            if ({o_valid, o_btn_idx, o_event_type} !== 5'b1_01_00) unstable++;
            if (c == 25) chk("bp_ovf", o_overflow, 4'b0001);
        end
        rise = '0; fall = '0; clr = 1'b0;
        chk("bp_stable", unstable, 0);
        chk("bp_ovf_clr_new", o_overflow, 4'b1000);
        rdy = 1'b1;
        tick;
        chk("bp_drain1", {o_valid, o_btn_idx, o_event_type}, {1'b1, 2'd3, 2'b00});
        tick;
        chk("bp_drain2", {o_valid, o_btn_idx, o_event_type}, {1'b1, 2'd0, 2'b00});
        tick;
        chk("bp_drained", o_valid, 1'b0);
        clr = 1'b1; tick; clr = 1'b0;
        chk("bp_clear", o_overflow, 4'b0000);

        // Reset while a press is held, events are pending and one is presented.
        do_reset; rdy = 1'b0;
        rise = 4'b1010; tick; rise = '0;
        fall = 4'b1010; tick; fall = '0;
        tick;
        rise = 4'b1000; tick; rise = '0;
        fall = 4'b1000; tick; fall = '0;
        rise = 4'b0001; tick; rise = '0;
        repeat (500) tick;
        chk("rst_pre", {o_valid, o_overflow}, {1'b1, 4'b1000});
        rst = 1'b1; tick; rst = 1'b0;
        chk("rst_out", {o_valid, o_btn_idx, o_event_type, o_overflow}, 9'd0);
        rdy = 1'b1;
        fall = 4'b0001; tick; fall = '0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (o_valid) cnt++;
        end
        chk("rst_no_event", cnt, 0);

        // Randomized run against the reference model.
        now = 0;
        model_reset;
        rst = 1'b1; rise = '0; fall = '0; clr = 1'b0;
        model_step(rise, fall, rdy, clr, rst);
        tick;
        stall = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            for (int b = 0; b < N; b++) begin
                rise[b] = $urandom_range(0, 99) < 3;
                fall[b] = $urandom_range(0, 999) < (((c / 2000) % 2) ? 150 : 2);
            end
            if ($urandom_range(0, 99) == 0) stall = !stall;
            rdy = stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) != 0);
            clr = $urandom_range(0, 299) == 0;
            rst = $urandom_range(0, 4999) == 0;
            model_step(rise, fall, rdy, clr, rst);
            tick;
            exp_w = {m_v, m_v ? 2'(m_idx) : 2'b00, m_v ? 2'(m_type) : 2'b00, m_ovf};
            act_w = {o_valid, m_v ? o_btn_idx : 2'b00, m_v ? o_event_type : 2'b00, o_overflow};
            chk($sformatf("rand_c%0d", c), act_w, exp_w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
